// File: rtl/pdi_pixel_processor_pkg.sv
// Shared definitions for the PDI pixel processor: operation codes, luma
// weights, FSM state encodings and the saturating-add helper.
package pdi_pixel_processor_pkg;

    // Per-pixel operation selected at start.
    typedef enum logic [1:0] {
        OP_PASS   = 2'b00,
        OP_INVERT = 2'b01,
        OP_GRAY   = 2'b10,
        OP_BRIGHT = 2'b11
    } pdi_op_e;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } pdi_state_e;

    // BRAM read latency in cycles; the write address trails the read
    // address by this latency plus the ALU register stage.
    localparam int unsigned PDI_BRAM_LAT = 1;

    // Luma weights; they sum to 256 so (sum >> 8) never exceeds 255.
    localparam logic [7:0] LUMA_R_W = 8'd77;
    localparam logic [7:0] LUMA_G_W = 8'd150;
    localparam logic [7:0] LUMA_B_W = 8'd29;

    // 8-bit add of a brighten offset with saturation at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] p);
        logic [8:0] sum_v;
        sum_v = {1'b0, x} + {1'b0, p};
        if (sum_v[8]) begin
            return 8'hFF;
        end else begin
            return sum_v[7:0];
        end
    endfunction

endpackage

// File: rtl/pdi_pixel_processor_alu.sv
// Combinational per-pixel ALU: applies pass / invert / grayscale / brighten
// to one R/G/B triple. The top module registers the result.
module pdi_pixel_processor_alu
    import pdi_pixel_processor_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] param,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out
);

    logic [15:0] luma_sum_s;
    logic [7:0]  luma_s;

    // Weighted luma sum; 16 bits is enough because the weights total 256.
    always_comb begin
        luma_sum_s = ({8'd0, LUMA_R_W} * {8'd0, red_in})
                   + ({8'd0, LUMA_G_W} * {8'd0, green_in})
                   + ({8'd0, LUMA_B_W} * {8'd0, blue_in});
        luma_s     = luma_sum_s[15:8];
    end

    // Operation select; unknown codes fall back to pass-through.
    always_comb begin
        red_out   = red_in;
        green_out = green_in;
        blue_out  = blue_in;
        case (op)
            OP_PASS: begin
                red_out   = red_in;
                green_out = green_in;
                blue_out  = blue_in;
            end
            OP_INVERT: begin
                red_out   = 8'd255 - red_in;
                green_out = 8'd255 - green_in;
                blue_out  = 8'd255 - blue_in;
            end
            OP_GRAY: begin
                red_out   = luma_s;
                green_out = luma_s;
                blue_out  = luma_s;
            end
            OP_BRIGHT: begin
                red_out   = sat_add8(red_in, param);
                green_out = sat_add8(green_in, param);
                blue_out  = sat_add8(blue_in, param);
            end
            default: begin
                red_out   = red_in;
                green_out = green_in;
                blue_out  = blue_in;
            end
        endcase
    end

endmodule

// File: rtl/pdi_pixel_processor.sv
// PDI pixel processor: streams every pixel address to the three-channel
// BRAM, runs the R/G/B triple through the ALU and writes it back in place,
// one pixel per clock. Holds pdi_active for the whole run.
module pdi_pixel_processor
    import pdi_pixel_processor_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned NUM_PIXELS = 76800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [7:0]        param,
    input  logic [7:0]        red_data_in,
    input  logic [7:0]        green_data_in,
    input  logic [7:0]        blue_data_in,
    output logic [ADDR_W-1:0] pdi_addr_read,
    output logic [ADDR_W-1:0] pdi_addr_write,
    output logic              pdi_we,
    output logic              pdi_active,
    output logic [7:0]        red_data_out,
    output logic [7:0]        green_data_out,
    output logic [7:0]        blue_data_out,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    // FSM and address counter
    pdi_state_e        state_r, state_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_nxt_s;
    logic              drain_cnt_r, drain_cnt_nxt_s;
    logic [1:0]        op_r, op_nxt_s;
    logic [7:0]        param_r, param_nxt_s;
    logic              rd_issue_s;
    logic              busy_r;
    logic              done_r;

    // Pipeline: stage 1 tracks the read in flight, stage 2 is the write
    logic              v1_r;
    logic [ADDR_W-1:0] a1_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_w_r;
    logic [7:0]        red_r, green_r, blue_r;

    logic [7:0]        alu_red_s, alu_green_s, alu_blue_s;

    pdi_pixel_processor_alu u_alu (
        .op        (op_r),
        .param     (param_r),
        .red_in    (red_data_in),
        .green_in  (green_data_in),
        .blue_in   (blue_data_in),
        .red_out   (alu_red_s),
        .green_out (alu_green_s),
        .blue_out  (alu_blue_s)
    );

    // Next-state logic: address stepping, drain count and start-time latching
    always_comb begin
        state_nxt_s     = state_r;
        rd_addr_nxt_s   = rd_addr_r;
        drain_cnt_nxt_s = drain_cnt_r;
        op_nxt_s        = op_r;
        param_nxt_s     = param_r;
        rd_issue_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_addr_nxt_s   = {ADDR_W{1'b0}};
                drain_cnt_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s = ST_RUN;
                    op_nxt_s    = op;
                    param_nxt_s = param;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rd_issue_s = 1'b1;
                if (rd_addr_r == LAST_ADDR) begin
                    // Hold the last address through DRAIN; never wrap.
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = 1'b0;
                end else begin
                    rd_addr_nxt_s = rd_addr_r + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r) begin
                    state_nxt_s   = ST_DONE;
                    rd_addr_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    drain_cnt_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s   = ST_IDLE;
                rd_addr_nxt_s = {ADDR_W{1'b0}};
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                rd_addr_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rd_addr_r   <= {ADDR_W{1'b0}};
            drain_cnt_r <= 1'b0;
            op_r        <= 2'b00;
            param_r     <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rd_addr_r   <= rd_addr_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            op_r        <= op_nxt_s;
            param_r     <= param_nxt_s;
            busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Address/valid delay line and ALU output register; write data and
    // write address are forced to zero whenever no write is presented,
    // since the BRAM ORs PDI data with the COM byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            a1_r     <= {ADDR_W{1'b0}};
            we_r     <= 1'b0;
            addr_w_r <= {ADDR_W{1'b0}};
            red_r    <= 8'd0;
            green_r  <= 8'd0;
            blue_r   <= 8'd0;
        end else begin
            v1_r <= rd_issue_s;
            a1_r <= rd_issue_s ? rd_addr_r : {ADDR_W{1'b0}};
            we_r <= v1_r;
            if (v1_r) begin
                addr_w_r <= a1_r;
                red_r    <= alu_red_s;
                green_r  <= alu_green_s;
                blue_r   <= alu_blue_s;
            end else begin
                addr_w_r <= {ADDR_W{1'b0}};
                red_r    <= 8'd0;
                green_r  <= 8'd0;
                blue_r   <= 8'd0;
            end
        end
    end

    assign pdi_addr_read  = rd_addr_r;
    assign pdi_addr_write = addr_w_r;
    assign pdi_we         = we_r;
    assign pdi_active     = busy_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign red_data_out   = red_r;
    assign green_data_out = green_r;
    assign blue_data_out  = blue_r;

endmodule

// File: tb/tb_pdi_pixel_processor.sv
// Self-checking bench: a 16-pixel instance against a 1-cycle-read BRAM
// model driven from a vector table, plus hand-written sequences for
// mid-run reset, ignored start/op changes and a 1-pixel back-to-back run.
module tb_pdi_pixel_processor;

    localparam int NP = 16;
    localparam int AW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [1:0]    op;
    logic [7:0]    param;
    logic [7:0]    rd_r, rd_g, rd_b;
    logic [AW-1:0] addr_rd, addr_wr;
    logic          we, active, busy, done;
    logic [7:0]    wr_r, wr_g, wr_b;

    logic          start_b;
    logic [7:0]    rd_r_b, rd_g_b, rd_b_b;
    logic [AW-1:0] addr_rd_b, addr_wr_b;
    logic          we_b, active_b, busy_b, done_b;
    logic [7:0]    wr_r_b, wr_g_b, wr_b_b;

    pdi_pixel_processor #(.ADDR_W(AW), .NUM_PIXELS(NP)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .param(param),
        .red_data_in(rd_r), .green_data_in(rd_g), .blue_data_in(rd_b),
        .pdi_addr_read(addr_rd), .pdi_addr_write(addr_wr), .pdi_we(we),
        .pdi_active(active), .red_data_out(wr_r), .green_data_out(wr_g),
        .blue_data_out(wr_b), .busy(busy), .done(done)
    );

    pdi_pixel_processor #(.ADDR_W(AW), .NUM_PIXELS(1)) dut_one (
        .clk(clk), .rst(rst), .start(start_b), .op(2'b00), .param(8'd0),
        .red_data_in(rd_r_b), .green_data_in(rd_g_b), .blue_data_in(rd_b_b),
        .pdi_addr_read(addr_rd_b), .pdi_addr_write(addr_wr_b), .pdi_we(we_b),
        .pdi_active(active_b), .red_data_out(wr_r_b), .green_data_out(wr_g_b),
        .blue_data_out(wr_b_b), .busy(busy_b), .done(done_b)
    );

    // BRAM model: 1-cycle synchronous read, write-back on pdi_we
    logic [7:0] mem_r [NP];
    logic [7:0] mem_g [NP];
    logic [7:0] mem_b [NP];
    logic [7:0] exp_r [NP];
    logic [7:0] exp_g [NP];
    logic [7:0] exp_b [NP];

    always @(posedge clk) begin
        rd_r <= mem_r[addr_rd[3:0]];
        rd_g <= mem_g[addr_rd[3:0]];
        rd_b <= mem_b[addr_rd[3:0]];
        if (we) begin
            mem_r[addr_wr[3:0]] <= wr_r;
            mem_g[addr_wr[3:0]] <= wr_g;
            mem_b[addr_wr[3:0]] <= wr_b;
        end
        rd_r_b <= 8'd7;
        rd_g_b <= 8'd8;
        rd_b_b <= 8'd9;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] param;
        logic [7:0] r, g, b;
        logic [7:0] er, eg, eb;
    } vec_t;

    vec_t vecs[10];

    task automatic fill_uniform(input logic [7:0] r, g, b, er, eg, eb);
        for (int a = 0; a < NP; a++) begin
            mem_r[a] = r;  mem_g[a] = g;  mem_b[a] = b;
            exp_r[a] = er; exp_g[a] = eg; exp_b[a] = eb;
        end
    endtask

    // One full run on the 16-pixel instance, checked cycle by cycle.
    // disturb pulses start at cycles 5 and 10 and flips op every cycle.
    task automatic run_check(input logic [1:0] run_op, input logic [7:0] run_param,
                             input bit disturb, input string tag);
        bit exp_we;
        @(negedge clk);
        op = run_op; param = run_param; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= NP + 4; c++) begin
            if (disturb) begin
                op    = ~op;
                param = param + 8'd1;
                start = (c == 5) || (c == 10);
            end
            exp_we = (c >= 3) && (c <= NP + 2);
            chk($sformatf("%s c%0d we", tag, c), int'(we), int'(exp_we));
            chk($sformatf("%s c%0d busy", tag, c), int'(busy), int'(c <= NP + 2));
            chk($sformatf("%s c%0d active", tag, c), int'(active), int'(c <= NP + 2));
            chk($sformatf("%s c%0d done", tag, c), int'(done), int'(c == NP + 3));
            if (c <= NP)
                chk($sformatf("%s c%0d rdaddr", tag, c), int'(addr_rd), c - 1);
            else if (c <= NP + 2)
                chk($sformatf("%s c%0d rdaddr_hold", tag, c), int'(addr_rd), NP - 1);
            else if (c == NP + 4)
                chk($sformatf("%s c%0d rdaddr_idle", tag, c), int'(addr_rd), 0);
            if (exp_we) begin
                chk($sformatf("%s c%0d wraddr", tag, c), int'(addr_wr), c - 3);
                chk($sformatf("%s c%0d red", tag, c), int'(wr_r), int'(exp_r[c-3]));
                chk($sformatf("%s c%0d green", tag, c), int'(wr_g), int'(exp_g[c-3]));
                chk($sformatf("%s c%0d blue", tag, c), int'(wr_b), int'(exp_b[c-3]));
            end else begin
                chk($sformatf("%s c%0d idle_data", tag, c), int'(wr_r | wr_g | wr_b), 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        // op, param, R, G, B -> expected R, G, B
        vecs[0] = '{2'b00, 8'd0,   8'd12,  8'd34,  8'd56,  8'd12,  8'd34,  8'd56};
        vecs[1] = '{2'b01, 8'd0,   8'd0,   8'd128, 8'd255, 8'd255, 8'd127, 8'd0};
        // (15400 + 15000 + 1450) = 31850, >> 8 = 124
        vecs[2] = '{2'b10, 8'd0,   8'd200, 8'd100, 8'd50,  8'd124, 8'd124, 8'd124};
        // 256 * 255 >> 8 = 255: full-scale white, no overflow
        vecs[3] = '{2'b10, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        // 77 * 255 = 19635, >> 8 = 76
        vecs[4] = '{2'b10, 8'd0,   8'd255, 8'd0,   8'd0,   8'd76,  8'd76,  8'd76};
        vecs[5] = '{2'b11, 8'd100, 8'd10,  8'd155, 8'd250, 8'd110, 8'd255, 8'd255};
        vecs[6] = '{2'b11, 8'd0,   8'd1,   8'd2,   8'd3,   8'd1,   8'd2,   8'd3};
        vecs[7] = '{2'b11, 8'd255, 8'd0,   8'd1,   8'd255, 8'd255, 8'd255, 8'd255};
        vecs[8] = '{2'b11, 8'd100, 8'd154, 8'd0,   8'd156, 8'd254, 8'd100, 8'd255};
        vecs[9] = '{2'b00, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};

        rst = 1'b1; start = 1'b0; start_b = 1'b0; op = 2'b00; param = 8'd0;
        fill_uniform(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("reset we", int'(we), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset active", int'(active), 0);
        chk("reset done", int'(done), 0);
        chk("reset rdaddr", int'(addr_rd), 0);
        chk("reset wraddr", int'(addr_wr), 0);
        chk("reset data", int'(wr_r | wr_g | wr_b), 0);
        rst = 1'b0;

        // Table-driven runs, uniform pixel data per run
        for (int v = 0; v < 10; v++) begin
            fill_uniform(vecs[v].r, vecs[v].g, vecs[v].b, vecs[v].er, vecs[v].eg, vecs[v].eb);
            run_check(vecs[v].op, vecs[v].param, 1'b0, $sformatf("vec%0d", v));
        end

        // Invert with R=G=B=addr; start pulses and op toggles mid-run ignored
        for (int a = 0; a < NP; a++) begin
            mem_r[a] = 8'(a); mem_g[a] = 8'(a); mem_b[a] = 8'(a);
            exp_r[a] = 8'(255 - a); exp_g[a] = 8'(255 - a); exp_b[a] = 8'(255 - a);
        end
        run_check(2'b01, 8'd0, 1'b1, "inv_disturb");

        // Reset at cycle 6 aborts the run immediately
        fill_uniform(8'd40, 8'd50, 8'd60, 8'd40, 8'd50, 8'd60);
        @(negedge clk);
        op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst we", int'(we), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst active", int'(active), 0);
        chk("midrst rdaddr", int'(addr_rd), 0);
        chk("midrst wraddr", int'(addr_wr), 0);
        chk("midrst data", int'(wr_r | wr_g | wr_b), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("postrst %0d we", c), int'(we), 0);
            chk($sformatf("postrst %0d busy", c), int'(busy), 0);
        end
        run_check(2'b00, 8'd0, 1'b0, "after_rst");

        // NUM_PIXELS=1 with start held high: back-to-back runs
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("one c%0d we", c), int'(we_b), int'(c == 3 || c == 8));
            chk($sformatf("one c%0d busy", c), int'(busy_b),
                int'((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            chk($sformatf("one c%0d active", c), int'(active_b),
                int'((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            chk($sformatf("one c%0d done", c), int'(done_b), int'(c == 4 || c == 9));
            chk($sformatf("one c%0d rdaddr", c), int'(addr_rd_b), 0);
            if (c == 3 || c == 8) begin
                chk($sformatf("one c%0d wraddr", c), int'(addr_wr_b), 0);
                chk($sformatf("one c%0d rgb", c),
                    int'({wr_r_b, wr_g_b, wr_b_b}), int'({8'd7, 8'd8, 8'd9}));
            end else begin
                chk($sformatf("one c%0d idle_data", c), int'(wr_r_b | wr_g_b | wr_b_b), 0);
            end
            if (c == 6) start_b = 1'b0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
